// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: sync, debounce, press/release pulses, hold flag.
// Optional auto-repeat on rpt_o is built when BTN_CONDITIONER_REPEAT_EN is defined.

module btn_chan #(
  parameter int DB_CYC   = 500000,
  parameter int HOLD_CYC = 50000000,
  parameter int RPT_CYC  = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold,
  output logic o_rpt
);
  localparam int DW   = $clog2(DB_CYC);
  localparam int HMAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int HW   = $clog2(HMAX + 1);

  typedef enum logic [1:0] {IDLE, ARMED, HELD} state_t;

  logic          r_s1, r_s2;
  logic          r_level, r_press, r_release;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;
  state_t        r_state;

  logic          w_level_nxt, w_press_nxt, w_release_nxt;
  logic [DW-1:0] w_dcnt_nxt;
  logic [HW-1:0] w_hcnt_nxt;
  state_t        w_state_nxt;

  always_comb begin
    w_level_nxt   = r_level;
    w_dcnt_nxt    = '0;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    if (r_s2 != r_level) begin
      if (r_dcnt == DW'(DB_CYC - 1)) begin
        w_level_nxt   = r_s2;
        w_press_nxt   = r_s2;
        w_release_nxt = ~r_s2;
      end else begin
        w_dcnt_nxt = r_dcnt + 1'b1;
      end
    end
    // Hold tracks the next level so hold drops on the same cycle release pulses.
    w_hcnt_nxt = '0;
    if (w_level_nxt && !w_press_nxt)
      w_hcnt_nxt = (r_hcnt == HW'(HOLD_CYC)) ? r_hcnt : r_hcnt + 1'b1;
    w_state_nxt = IDLE;
    if (w_level_nxt)
      w_state_nxt = (w_hcnt_nxt == HW'(HOLD_CYC)) ? HELD : ARMED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_dcnt    <= '0;
      r_hcnt    <= '0;
      r_state   <= IDLE;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_state   <= w_state_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_hold    = (r_state == HELD);

`ifdef BTN_CONDITIONER_REPEAT_EN
  logic [HW-1:0] r_rcnt, w_rcnt_nxt;
  logic          r_rpt, w_rpt_nxt;

  // First pulse on entry to HELD, then one every RPT_CYC; leaving HELD kills the slot.
  always_comb begin
    w_rcnt_nxt = '0;
    w_rpt_nxt  = 1'b0;
    if (w_state_nxt == HELD) begin
      if (r_state != HELD || r_rcnt == HW'(RPT_CYC - 1))
        w_rpt_nxt = 1'b1;
      else
        w_rcnt_nxt = r_rcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt <= '0;
      r_rpt  <= 1'b0;
    end else begin
      r_rcnt <= w_rcnt_nxt;
      r_rpt  <= w_rpt_nxt;
    end
  end

  assign o_rpt = r_rpt;
`else
  assign o_rpt = 1'b0;
`endif
endmodule

module btn_conditioner #(
  parameter int              N_CH     = 3,
  parameter int              DB_CYC   = 500000,
  parameter int              HOLD_CYC = 50000000,
  parameter int              RPT_CYC  = 10000000,
  parameter logic [N_CH-1:0] INV_MASK = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] hold_o,
  output logic [N_CH-1:0] rpt_o
);
  logic [N_CH-1:0] w_raw;

  assign w_raw = btn_i ^ INV_MASK;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_chan #(
      .DB_CYC   (DB_CYC),
      .HOLD_CYC (HOLD_CYC),
      .RPT_CYC  (RPT_CYC)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (w_raw[g]),
      .o_level   (level_o[g]),
      .o_press   (press_o[g]),
      .o_release (release_o[g]),
      .o_hold    (hold_o[g]),
      .o_rpt     (rpt_o[g])
    );
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: N_CH=3, DB_CYC=4, HOLD_CYC=10, RPT_CYC=3, INV_MASK=3'b100.
// Inputs change and outputs are sampled on the falling edge; one tick = one clock cycle.

module tb_btn_conditioner;
  logic       clk;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] level, press, rel, hold, rpt;
  int         n_chk;
  int         n_fail;

  btn_conditioner #(
    .N_CH     (3),
    .DB_CYC   (4),
    .HOLD_CYC (10),
    .RPT_CYC  (3),
    .INV_MASK (3'b100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_i     (btn),
    .level_o   (level),
    .press_o   (press),
    .release_o (rel),
    .hold_o    (hold),
    .rpt_o     (rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] rx(input logic [2:0] v);
`ifdef BTN_CONDITIONER_REPEAT_EN
    return v;
`else
    return 3'b000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_lvl, input logic [2:0] e_prs,
                         input logic [2:0] e_rel, input logic [2:0] e_hld, input logic [2:0] e_rpt);
    chk({tag, ".level"},   level, e_lvl);
    chk({tag, ".press"},   press, e_prs);
    chk({tag, ".release"}, rel,   e_rel);
    chk({tag, ".hold"},    hold,  e_hld);
    chk({tag, ".rpt"},     rpt,   e_rpt);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    btn    = 3'b100;
    tick(3);
    chk_all("reset", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    tick(8);
    chk_all("idle", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    // Clean press on ch0, then hold / repeat / release
    btn[0] = 1'b1;
    tick(5);  chk_all("cp.c5",  3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);  chk_all("cp.c6",  3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    tick(1);  chk_all("cp.c7",  3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(8);  chk_all("hr.c15", 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);  chk_all("hr.c16", 3'b001, 3'b000, 3'b000, 3'b001, rx(3'b001));
    tick(1);  chk_all("hr.c17", 3'b001, 3'b000, 3'b000, 3'b001, 3'b000);
    tick(2);  chk_all("hr.c19", 3'b001, 3'b000, 3'b000, 3'b001, rx(3'b001));
    tick(3);  chk_all("hr.c22", 3'b001, 3'b000, 3'b000, 3'b001, rx(3'b001));
    btn[0] = 1'b0;
    tick(3);  chk_all("hr.c25", 3'b001, 3'b000, 3'b000, 3'b001, rx(3'b001));
    tick(2);  chk_all("hr.c27", 3'b001, 3'b000, 3'b000, 3'b001, 3'b000);
    tick(1);  chk_all("hr.c28", 3'b000, 3'b000, 3'b001, 3'b000, 3'b000);
    tick(1);  chk_all("hr.c29", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(4);  chk_all("hr.c33", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    // 3-cycle glitch on ch1 must be rejected
    btn[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1); chk_all("gl.hi", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    end
    btn[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1); chk_all("gl.lo", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    end

    // 4-cycle pulse on ch1 is accepted
    btn[1] = 1'b1;
    tick(4);
    btn[1] = 1'b0;
    tick(1);  chk_all("p4.c5",  3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);  chk_all("p4.c6",  3'b010, 3'b010, 3'b000, 3'b000, 3'b000);
    tick(3);  chk_all("p4.c9",  3'b010, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);  chk_all("p4.c10", 3'b000, 3'b000, 3'b010, 3'b000, 3'b000);
    tick(3);

    // Active-low ch2: pin drop is a press
    btn[2] = 1'b0;
    tick(5);  chk_all("al.c5",  3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);  chk_all("al.c6",  3'b100, 3'b100, 3'b000, 3'b000, 3'b000);
    tick(1);  chk_all("al.c7",  3'b100, 3'b000, 3'b000, 3'b000, 3'b000);
    btn[2] = 1'b1;
    tick(6);  chk_all("al.rel", 3'b000, 3'b000, 3'b100, 3'b000, 3'b000);
    tick(3);

    // Simultaneous press on ch0/ch1, reset mid-press, re-issue afterwards
    btn[1:0] = 2'b11;
    tick(6);  chk_all("sr.c6",  3'b011, 3'b011, 3'b000, 3'b000, 3'b000);
    tick(6);  chk_all("sr.c12", 3'b011, 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b1;
    tick(1);  chk_all("sr.c13", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);
    rst = 1'b0;
    tick(5);  chk_all("sr.c19", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);  chk_all("sr.c20", 3'b011, 3'b011, 3'b000, 3'b000, 3'b000);
    tick(10); chk_all("sr.c30", 3'b011, 3'b000, 3'b000, 3'b011, rx(3'b011));
    btn[1:0] = 2'b00;
    tick(6);  chk_all("sr.c36", 3'b000, 3'b000, 3'b011, 3'b000, 3'b000);
    tick(2);  chk_all("sr.c38", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised N-channel push-button input conditioner: two-flop synchroniser, per-channel debounce counter, edge pulses, long-press hold flag and optional auto-repeat. It sits directly behind the board button and reset pins on the 100 MHz `clk` domain. It replaces per-button debounce instances and feeds clean levels and one-cycle events to `game_logic`, `buzzer_module` and menu logic.

## Interface
- `N_CH`, 3, number of independent button channels (1..16)
- `DB_CYC`, 500000, consecutive stable cycles required to accept a new level (≥2; 5 ms at 100 MHz)
- `HOLD_CYC`, 50000000, cycles a debounced press must persist before `hold_o` asserts (≥1; 0.5 s)
- `RPT_CYC`, 10000000, auto-repeat period once held (≥1; 0.1 s)
- `INV_MASK`, 0, N_CH-bit mask; bit set = that channel's pin is active-low and is inverted before synchronisation
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous, active-high reset
- `btn_i`  in  N_CH  raw asynchronous button pins
- `level_o`  out  N_CH  debounced pressed level (1 = pressed after INV_MASK applied)
- `press_o`  out  N_CH  one-cycle pulse on debounced 0→1
- `release_o`  out  N_CH  one-cycle pulse on debounced 1→0
- `hold_o`  out  N_CH  high while pressed and held ≥ HOLD_CYC cycles
- `rpt_o`  out  N_CH  one-cycle auto-repeat pulses (macro-dependent)

## Operation
- Channel i: `raw = btn_i[i] ^ INV_MASK[i]` → `s1` → `s2` (two flops, no logic between them).
- Debounce counter `dcnt`, width `$clog2(DB_CYC)`, per channel, each cycle:
  - `s2 == level`: `dcnt <= 0`.
  - else if `dcnt == DB_CYC-1`: `level <= s2`, `dcnt <= 0`, and the matching `press`/`release` register is set for exactly that cycle.
  - else `dcnt <= dcnt+1`.
- A glitch shorter than DB_CYC cycles resets `dcnt` when `s2` returns to `level`, so it produces no event.
- Hold counter `hcnt`, width `$clog2(max(HOLD_CYC,RPT_CYC)+1)`, per channel:
  - Cleared whenever `level == 0`, and on the press cycle.
  - Increments while `level == 1` and saturates at HOLD_CYC.
  - `hold_o` = (`hcnt == HOLD_CYC`), registered.
- Per-channel states: IDLE (level 0) → ARMED (pressed, hcnt < HOLD_CYC) → HELD (hold_o=1) → IDLE on release. A release from any state returns to IDLE and clears `hold_o` in the same cycle `release_o` pulses.
- Channels are fully independent. Simultaneous events on different channels each pulse in their own bit in the same cycle.

## Timing
- Reset values: `s1`, `s2`, `level_o`, `press_o`, `release_o`, `hold_o`, `rpt_o` all 0; `dcnt`, `hcnt`, `rcnt` all 0. `rst` overrides all other activity, including mid-debounce and mid-hold.
- A pin already active at reset release produces a normal `press_o` after the debounce latency.
- Latency, pin step at edge t (held stable) to `level_o`/`press_o` high: sampled into `s1` at t+1, `s2` at t+2, `level_o` and `press_o` at t+2+DB_CYC.
- `press_o` and `release_o` are high for exactly 1 cycle and are never high together on one channel.
- `hold_o` rises HOLD_CYC cycles after the `press_o` cycle.
- All outputs are registered; no combinational path from `btn_i`.

## Configuration
- `BTN_CONDITIONER_REPEAT_EN` defined:
  - A per-channel repeat counter `rcnt` runs in HELD.
  - `rpt_o` pulses on the cycle `hold_o` first rises, then every RPT_CYC cycles while held.
  - `rcnt` clears on release or `rst`.
  - A release coinciding with a repeat slot suppresses that `rpt_o` pulse.
- Not defined: `rcnt` logic is absent and `rpt_o` is tied to 0. All other behaviour is identical.

## Test plan
Parameters for all scenarios: N_CH=3, DB_CYC=4, HOLD_CYC=10, RPT_CYC=3, INV_MASK=3'b100.
- Clean press: `btn_i[0]` 0→1 at cycle 0 → `level_o[0]`=1 and `press_o[0]`=1 at cycle 6; `press_o[0]`=0 at cycle 7; no activity on other channels.
- Glitch reject: `btn_i[1]` high for 3 cycles then low → `level_o`, `press_o` and `release_o` stay 0 throughout; a 4-cycle synced pulse is accepted.
- Hold and repeat with macro defined: `btn_i[0]` held → `hold_o[0]` rises at cycle 16; `rpt_o[0]` pulses at cycles 16, 19, 22. Release → `release_o[0]` pulse and `hold_o[0]` low in the same cycle; no further `rpt_o`. Without the macro, `rpt_o` stays 0.
- Active-low channel: `btn_i[2]` held 1 from reset, then driven 0 → `press_o[2]` 6 cycles after the drop.
- Simultaneous events plus reset: press ch0 and ch1 on the same cycle → both `press_o` bits high on one cycle. Assert `rst` at cycle 12 → all outputs 0 on the next cycle. Pins still held after reset → `press_o` re-issues 6 cycles after `rst` deasserts.
